// File: rtl/bus_mem_responder.sv
// bus_mem_responder: single-port word memory acting as responder on the copperv data bus.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   dr_addr_valid/ready, dr_addr       read address channel (byte address)
//   dr_data_valid/ready, dr_data       read data channel
//   dw_data_addr_valid/ready, dw_addr, dw_data, dw_strobe
//                                      write channel (address, data, byte enables)
//   dw_resp_valid/ready, dw_resp       write response channel (0 = OK, 1 = ERROR)
//
// Word index is addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored. Addresses at or above
// 4*2**DEPTH_LOG2 read as zero and are rejected on write with resp=1.
// Read data appears exactly RD_LATENCY cycles after address acceptance.
module bus_mem_responder #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned RESP_WIDTH = 1,
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dr_addr_valid,
   output logic                    dr_addr_ready,
   input  logic [BUS_WIDTH-1:0]    dr_addr,
   output logic                    dr_data_valid,
   input  logic                    dr_data_ready,
   output logic [BUS_WIDTH-1:0]    dr_data,
   input  logic                    dw_data_addr_valid,
   output logic                    dw_data_addr_ready,
   input  logic [BUS_WIDTH-1:0]    dw_addr,
   input  logic [BUS_WIDTH-1:0]    dw_data,
   input  logic [BUS_WIDTH/8-1:0]  dw_strobe,
   output logic                    dw_resp_valid,
   input  logic                    dw_resp_ready,
   output logic [RESP_WIDTH-1:0]   dw_resp
);

   localparam int unsigned StrbWidth = BUS_WIDTH / 8;
   localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
   localparam int unsigned CntWidth  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CntWidth-1:0] CntInit = CntWidth'(RD_LATENCY - 1);

   typedef enum logic [1:0] {RIdle, RWait, RResp} rd_state_e;
   typedef enum logic {WIdle, WResp} wr_state_e;

   rd_state_e rd_state_q, rd_state_d;
   wr_state_e wr_state_q, wr_state_d;

   logic [BUS_WIDTH-1:0]  mem_q [Depth];
   logic [BUS_WIDTH-1:0]  rd_word_q;
   logic                  rd_zero_q, rd_zero_d;
   logic [CntWidth-1:0]   rd_cnt_q, rd_cnt_d;
   logic [RESP_WIDTH-1:0] dw_resp_q, dw_resp_d;

   logic [DEPTH_LOG2-1:0] rd_idx, wr_idx;
   logic                  rd_in_range, wr_in_range;
   logic                  rd_accept, wr_accept;
   logic                  rd_en, wr_en;
   logic                  unused_addr_bits;

   assign rd_idx      = dr_addr[DEPTH_LOG2+1:2];
   assign wr_idx      = dw_addr[DEPTH_LOG2+1:2];
   assign rd_in_range = ~|dr_addr[BUS_WIDTH-1:DEPTH_LOG2+2];
   assign wr_in_range = ~|dw_addr[BUS_WIDTH-1:DEPTH_LOG2+2];
   assign unused_addr_bits = ^{dr_addr[1:0], dw_addr[1:0]};

   assign rd_accept = (rd_state_q == RIdle) && dr_addr_valid;
   assign wr_accept = (wr_state_q == WIdle) && dw_data_addr_valid;
   assign rd_en     = rd_accept && rd_in_range;
   // A write accepted on a reset edge is dropped along with the rest of the write state.
   assign wr_en     = wr_accept && wr_in_range && !rst;

   // Memory port. The read samples the array before the same-edge write lands,
   // so a simultaneous read of the same word returns the old value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < StrbWidth; b++) begin
            if (dw_strobe[b]) begin
               mem_q[wr_idx][8*b +: 8] <= dw_data[8*b +: 8];
            end
         end
      end
      if (rd_en) begin
         rd_word_q <= mem_q[rd_idx];
      end
   end

   // rd_zero_q masks the data word: set by reset and by out-of-range reads.
   assign dr_data = rd_zero_q ? '0 : rd_word_q;
   assign dw_resp = dw_resp_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= RIdle;
         rd_cnt_q   <= '0;
         rd_zero_q  <= 1'b1;
         wr_state_q <= WIdle;
         dw_resp_q  <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_zero_q  <= rd_zero_d;
         wr_state_q <= wr_state_d;
         dw_resp_q  <= dw_resp_d;
      end
   end

   always_comb begin
      rd_state_d    = rd_state_q;
      rd_cnt_d      = rd_cnt_q;
      rd_zero_d     = rd_zero_q;
      dr_addr_ready = 1'b0;
      dr_data_valid = 1'b0;
      unique case (rd_state_q)
         RIdle: begin
            dr_addr_ready = 1'b1;
            if (dr_addr_valid) begin
               rd_zero_d  = !rd_in_range;
               rd_cnt_d   = CntInit;
               rd_state_d = (CntInit == '0) ? RResp : RWait;
            end
         end
         RWait: begin
            rd_cnt_d = rd_cnt_q - CntWidth'(1);
            if (rd_cnt_q == CntWidth'(1)) begin
               rd_state_d = RResp;
            end
         end
         RResp: begin
            dr_data_valid = 1'b1;
            if (dr_data_ready) begin
               rd_state_d = RIdle;
            end
         end
         default: rd_state_d = RIdle;
      endcase
   end

   always_comb begin
      wr_state_d         = wr_state_q;
      dw_resp_d          = dw_resp_q;
      dw_data_addr_ready = 1'b0;
      dw_resp_valid      = 1'b0;
      unique case (wr_state_q)
         WIdle: begin
            dw_data_addr_ready = 1'b1;
            if (dw_data_addr_valid) begin
               dw_resp_d  = wr_in_range ? RESP_WIDTH'(0) : RESP_WIDTH'(1);
               wr_state_d = WResp;
            end
         end
         WResp: begin
            dw_resp_valid = 1'b1;
            if (dw_resp_ready) begin
               wr_state_d = WIdle;
            end
         end
         default: wr_state_d = WIdle;
      endcase
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

   localparam int unsigned BW  = 32;
   localparam int unsigned LAT = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          dr_addr_valid, dr_addr_ready;
   logic [BW-1:0] dr_addr;
   logic          dr_data_valid, dr_data_ready;
   logic [BW-1:0] dr_data;
   logic          dw_data_addr_valid, dw_data_addr_ready;
   logic [BW-1:0] dw_addr, dw_data;
   logic [3:0]    dw_strobe;
   logic          dw_resp_valid, dw_resp_ready;
   logic [0:0]    dw_resp;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] rd_q [$];
   logic [31:0] wr_q [$];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [22];

   bus_mem_responder #(
      .BUS_WIDTH (BW),
      .RESP_WIDTH(1),
      .DEPTH_LOG2(10),
      .RD_LATENCY(LAT)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .dr_addr_valid     (dr_addr_valid),
      .dr_addr_ready     (dr_addr_ready),
      .dr_addr           (dr_addr),
      .dr_data_valid     (dr_data_valid),
      .dr_data_ready     (dr_data_ready),
      .dr_data           (dr_data),
      .dw_data_addr_valid(dw_data_addr_valid),
      .dw_data_addr_ready(dw_data_addr_ready),
      .dw_addr           (dw_addr),
      .dw_data           (dw_data),
      .dw_strobe         (dw_strobe),
      .dw_resp_valid     (dw_resp_valid),
      .dw_resp_ready     (dw_resp_ready),
      .dw_resp           (dw_resp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: pop the expected value whenever a response handshake is about to happen.
   always @(negedge clk) begin
      if (!rst && dr_data_valid && dr_data_ready) begin
         if (rd_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_unexpected: got %h, expected no read response", dr_data);
         end else begin
            check("rd_data", dr_data, rd_q.pop_front());
         end
      end
      if (!rst && dw_resp_valid && dw_resp_ready) begin
         if (wr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wr_unexpected: got resp %h, expected no write response", dw_resp);
         end else begin
            check("wr_resp", 32'(dw_resp), wr_q.pop_front());
         end
      end
   end

   // Entry/exit point of every task: 1 time unit after a rising edge.
   task automatic wait_idle(input string name);
      int n;
      for (n = 0; n < 40; n++) begin
         if (dr_addr_ready && dw_data_addr_ready && !dr_data_valid && !dw_resp_valid) break;
         @(posedge clk); #1;
      end
      if (n == 40) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_timeout: got busy after 40 cycles, expected idle", name);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [31:0] exp_resp);
      int n;
      wr_q.push_back(exp_resp);
      dw_addr = a;
      dw_data = d;
      dw_strobe = s;
      dw_data_addr_valid = 1'b1;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (dw_data_addr_ready) break;
      end
      @(posedge clk); #1;
      dw_data_addr_valid = 1'b0;
      check("wr_accept", 32'(n < 20), 32'd1);
      check("wr_latency", 32'(dw_resp_valid), 32'd1);
      wait_idle("wr");
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
      int n;
      int lat;
      rd_q.push_back(exp);
      dr_addr = a;
      dr_addr_valid = 1'b1;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (dr_addr_ready) break;
      end
      @(posedge clk); #1;
      dr_addr_valid = 1'b0;
      check("rd_accept", 32'(n < 20), 32'd1);
      lat = 1;
      while (!dr_data_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rd_latency", 32'(lat), 32'(LAT));
      wait_idle("rd");
   endtask

   // Present a read and a write together; both channels are idle so both accept on one edge.
   task automatic issue_both(input logic [31:0] ra, input logic [31:0] rexp,
                             input logic [31:0] wa, input logic [31:0] wd,
                             input logic [3:0] ws, input logic [31:0] wexp);
      rd_q.push_back(rexp);
      wr_q.push_back(wexp);
      dr_addr = ra;
      dw_addr = wa;
      dw_data = wd;
      dw_strobe = ws;
      dr_addr_valid = 1'b1;
      dw_data_addr_valid = 1'b1;
      @(negedge clk);
      check("both_ready", {30'd0, dr_addr_ready, dw_data_addr_ready}, 32'd3);
      @(posedge clk); #1;
      dr_addr_valid = 1'b0;
      dw_data_addr_valid = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 32'd0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_BABE};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'd0};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'd0};
      vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD};
      vecs[5]  = '{1'b0, 32'h0000_0023, 32'h0,         4'h0, 32'h11BB_33DD};
      vecs[6]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 32'd0};
      vecs[7]  = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 32'd1};
      vecs[8]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678};
      vecs[10] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'h0};
      vecs[11] = '{1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, 32'd0};
      vecs[12] = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'd0};
      vecs[13] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0BAD_F00D};
      vecs[14] = '{1'b1, 32'h0000_0044, 32'h0000_0000, 4'hF, 32'd0};
      vecs[15] = '{1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'hA, 32'd0};
      vecs[16] = '{1'b0, 32'h0000_0044, 32'h0,         4'h0, 32'hAA00_CC00};
      vecs[17] = '{1'b1, 32'h0000_0FFC, 32'h5A5A_5A5A, 4'hF, 32'd0};
      vecs[18] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h5A5A_5A5A};
      vecs[19] = '{1'b1, 32'h0000_0030, 32'h0000_0000, 4'hF, 32'd0};
      vecs[20] = '{1'b1, 32'h0000_0FFF, 32'h0102_0304, 4'h3, 32'd0};
      vecs[21] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h5A5A_0304};

      rst = 1'b1;
      dr_addr_valid = 1'b0;
      dr_addr = '0;
      dr_data_ready = 1'b1;
      dw_data_addr_valid = 1'b0;
      dw_addr = '0;
      dw_data = '0;
      dw_strobe = '0;
      dw_resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_dr_addr_ready", 32'(dr_addr_ready), 32'd1);
      check("rst_dr_data_valid", 32'(dr_data_valid), 32'd0);
      check("rst_dr_data", dr_data, 32'd0);
      check("rst_dw_ready", 32'(dw_data_addr_ready), 32'd1);
      check("rst_dw_resp_valid", 32'(dw_resp_valid), 32'd0);
      check("rst_dw_resp", 32'(dw_resp), 32'd0);

      foreach (vecs[i]) begin
         if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp);
         else            do_read(vecs[i].addr, vecs[i].exp);
      end

      // Backpressure: both responses held for 5 cycles while new requests wait.
      dr_data_ready = 1'b0;
      dw_resp_ready = 1'b0;
      issue_both(32'h10, 32'hCAFE_BABE, 32'h50, 32'h1357_9BDF, 4'hF, 32'd0);
      repeat (LAT - 1) @(posedge clk);
      #1;
      dr_addr = 32'h20;
      dr_addr_valid = 1'b1;
      dw_addr = 32'h54;
      dw_data_addr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_rd_valid", 32'(dr_data_valid), 32'd1);
         check("hold_rd_data", dr_data, 32'hCAFE_BABE);
         check("hold_wr_valid", 32'(dw_resp_valid), 32'd1);
         check("hold_wr_resp", 32'(dw_resp), 32'd0);
         check("hold_readies", {30'd0, dr_addr_ready, dw_data_addr_ready}, 32'd0);
      end
      @(posedge clk); #1;
      dr_addr_valid = 1'b0;
      dw_data_addr_valid = 1'b0;
      dr_data_ready = 1'b1;
      dw_resp_ready = 1'b1;
      @(posedge clk); #1;
      check("release_valids", {30'd0, dr_data_valid, dw_resp_valid}, 32'd0);
      check("release_readies", {30'd0, dr_addr_ready, dw_data_addr_ready}, 32'd3);
      do_read(32'h50, 32'h1357_9BDF);

      // Same-edge read and write of one word: the read sees the old contents.
      issue_both(32'h30, 32'h0, 32'h30, 32'h5555_5555, 4'hF, 32'd0);
      wait_idle("same_edge");
      do_read(32'h30, 32'h5555_5555);

      // Reset while the read is waiting and the write response is stalled.
      dw_resp_ready = 1'b0;
      rd_q.push_back(32'h0);
      wr_q.push_back(32'h0);
      dr_addr = 32'h10;
      dw_addr = 32'h60;
      dw_data = 32'h600D_CAFE;
      dw_strobe = 4'hF;
      dr_addr_valid = 1'b1;
      dw_data_addr_valid = 1'b1;
      @(posedge clk); #1;
      dr_addr_valid = 1'b0;
      dw_data_addr_valid = 1'b0;
      check("pre_rst_rd_valid", 32'(dr_data_valid), 32'd0);
      check("pre_rst_wr_valid", 32'(dw_resp_valid), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rd_q.delete();
      wr_q.delete();
      check("mid_rst_rd_valid", 32'(dr_data_valid), 32'd0);
      check("mid_rst_wr_valid", 32'(dw_resp_valid), 32'd0);
      check("mid_rst_readies", {30'd0, dr_addr_ready, dw_data_addr_ready}, 32'd3);
      check("mid_rst_dr_data", dr_data, 32'd0);
      dw_resp_ready = 1'b1;
      do_read(32'h60, 32'h600D_CAFE);
      do_read(32'h10, 32'hCAFE_BABE);

      repeat (3) @(posedge clk);
      check("sb_rd_empty", 32'(rd_q.size()), 32'd0);
      check("sb_wr_empty", 32'(wr_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Single-port word memory that acts as the responder on the copperv data bus.
- Serves the dr channels (read address in, read data out) and the dw channels (write data+address in, write response out).
- Uses ready/valid handshakes on every channel.
- Replaces the behavioural memory behind the sim crossbar with synthesizable, latency-configurable RTL usable on FPGA and in sim.

Parameters:
- BUS_WIDTH, 32, address/data width; strobe width is BUS_WIDTH/8.
- RESP_WIDTH, 1, width of dw_resp.
- DEPTH_LOG2, 10, log2 of memory depth in words.
- RD_LATENCY, 2, cycles from read-address acceptance to dr_data_valid; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- dr_addr_valid  in  1  read address valid
- dr_addr_ready  out  1  read address ready
- dr_addr  in  BUS_WIDTH  read byte address
- dr_data_valid  out  1  read data valid
- dr_data_ready  in  1  read data ready
- dr_data  out  BUS_WIDTH  read data
- dw_data_addr_valid  in  1  write address+data valid
- dw_data_addr_ready  out  1  write address+data ready
- dw_addr  in  BUS_WIDTH  write byte address
- dw_data  in  BUS_WIDTH  write data
- dw_strobe  in  BUS_WIDTH/8  byte enables; bit i covers byte i
- dw_resp_valid  out  1  write response valid
- dw_resp_ready  in  1  write response ready
- dw_resp  out  RESP_WIDTH  0 = OK, 1 = ERROR

Behaviour:
- Reset: one clk, synchronous, active-high (rst=1 resets).
  - Outputs after reset: dr_addr_ready=1, dr_data_valid=0, dr_data=0, dw_data_addr_ready=1, dw_resp_valid=0, dw_resp=0.
  - Memory contents are not cleared.
  - Asserting rst mid-transaction discards all pending read/write state; a write already committed stays committed.
- Address decode:
  - word index = addr[DEPTH_LOG2+1:2]; addr[1:0] is ignored (no misalignment error).
  - Out of range when addr >= 4*2**DEPTH_LOG2.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: dr_addr_ready=1. On dr_addr_valid&&dr_addr_ready, capture the memory word (0 if out of range) and load a counter with RD_LATENCY-1.
    - Counter 0: go to R_RESP.
    - Otherwise: go to R_WAIT.
  - R_WAIT: dr_addr_ready=0. Decrement the counter; at 0 go to R_RESP.
  - R_RESP: dr_data_valid=1 and dr_data stable until dr_data_ready. On the handshake, go to R_IDLE with dr_data_valid=0 the next cycle.
  - Only one read is outstanding. Total latency is exactly RD_LATENCY cycles from acceptance edge to first dr_data_valid=1 when dr_data_ready is held high.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: dw_data_addr_ready=1. On handshake:
    - In range: bytes with strobe=1 are written at that edge, resp=0.
    - Out of range: no write, resp=1.
    - Go to W_RESP.
  - W_RESP: dw_data_addr_ready=0, dw_resp_valid=1, dw_resp stable until dw_resp_ready. Return to W_IDLE after the handshake.
  - Write-to-response latency is 1 cycle.
  - Strobe=0 writes still produce resp=0.
- Simultaneous read and write accepted on the same edge, same word: the read returns the pre-write value. A read accepted later sees the new data.
- Read and write channels are fully independent and may both be busy at once.
- valid may drop without a handshake (no protocol error). Inputs are sampled only on the handshake edge.

Test Plan:
- Write 0xCAFEBABE to 0x10 with strobe 0xF, dw_resp_ready=1; then read 0x10 with RD_LATENCY=2 -> dw_resp_valid=1, dw_resp=0 one cycle after acceptance; dr_data=0xCAFEBABE valid exactly 2 cycles after address acceptance.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD to 0x20 with strobe 0x5 -> read returns 0x11BB33DD.
- Write and read to address 4*2**DEPTH_LOG2 -> dw_resp=1, memory unchanged, dr_data=0.
- Hold dr_data_ready=0 and dw_resp_ready=0 for 5 cycles -> dr_data and dw_resp stay stable, both ready outputs stay 0, no new handshakes; release -> one-cycle handshake each, then readies return to 1.
- Same-edge read and write (0x55555555, strobe 0xF) to 0x30, which holds 0x0 -> read returns 0x0; a subsequent read returns 0x55555555.
- Assert rst while in R_WAIT and W_RESP -> next cycle dr_data_valid=0, dw_resp_valid=0, both readies=1; previously written data is still readable.
